// File: rtl/change_dispenser_if.sv
// ============================================================================
// Module   : change_dispenser_if
// Brief    : Request, sensor, restock and status signals of the nickel dispenser
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface change_dispenser_if #(
  parameter int AMT_W   = 4,
  parameter int STOCK_W = 6
);
  logic               req_valid;
  logic [AMT_W-1:0]   req_amount;
  logic               req_ready;
  logic               coin_sensed;
  logic               restock;
  logic [STOCK_W-1:0] restock_count;
  logic               clear_error;
  logic               eject_nickel;
  logic               busy;
  logic               done;
  logic               error;
  logic [AMT_W-1:0]   short_amount;
  logic [STOCK_W-1:0] stock_level;
  logic               empty;

  modport master (
    output req_valid, req_amount, coin_sensed, restock, restock_count, clear_error,
    input  req_ready, eject_nickel, busy, done, error, short_amount, stock_level, empty
  );

  modport slave (
    input  req_valid, req_amount, coin_sensed, restock, restock_count, clear_error,
    output req_ready, eject_nickel, busy, done, error, short_amount, stock_level, empty
  );
endinterface

`default_nettype wire

// File: rtl/change_dispenser.sv
// ============================================================================
// Module   : change_dispenser
// Brief    : Pays out change one nickel at a time, confirms each coin, tracks stock
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module change_dispenser #(
  parameter int AMT_W          = 4,
  parameter int STOCK_W        = 6,
  parameter int STOCK_INIT     = 20,
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  change_dispenser_if.slave    bus
);

  localparam int c_PW = $clog2(PULSE_CYCLES + 1);
  localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_PW-1:0] c_PULSE_LAST = c_PW'(PULSE_CYCLES - 1);
  localparam logic [c_TW-1:0] c_WAIT_LAST  = c_TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FIRE       = 3'd1,
    S_WAIT_SENSE = 3'd2,
    S_DONE       = 3'd3,
    S_FAULT      = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_ready;
  logic               r_eject;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic [AMT_W-1:0]   r_short;
  logic [AMT_W-1:0]   r_remaining;
  logic [STOCK_W-1:0] r_stock;
  logic [c_PW-1:0]    r_pulse;
  logic [c_TW-1:0]    r_wait;

  logic [STOCK_W:0]   w_sum;
  logic [STOCK_W-1:0] w_stock_idle;
  logic [STOCK_W-1:0] w_stock_dec;
  logic               w_last_coin;

  // Stock as it stands after this cycle's restock, saturated at all-ones
  always_comb begin
    w_sum        = {1'b0, r_stock} + {1'b0, bus.restock_count};
    w_stock_idle = r_stock;
    if (bus.restock) begin
      w_stock_idle = w_sum[STOCK_W] ? {STOCK_W{1'b1}} : w_sum[STOCK_W-1:0];
    end
  end

  assign w_stock_dec = r_stock - STOCK_W'(1);
  assign w_last_coin = (r_remaining == AMT_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_eject     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_short     <= '0;
      r_remaining <= '0;
      r_stock     <= STOCK_W'(STOCK_INIT);
      r_pulse     <= '0;
      r_wait      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_stock <= w_stock_idle;
          if (bus.req_valid) begin
            r_ready <= 1'b0;
            if (bus.req_amount == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_FIRE;
              r_busy      <= 1'b1;
              r_remaining <= bus.req_amount;
              r_pulse     <= '0;
              r_eject     <= (w_stock_idle != '0);
            end
          end
        end

        S_FIRE, S_WAIT_SENSE: begin
          // FIRE entered without a pulse means the tube was empty on entry
          if (r_state == S_FIRE && !r_eject) begin
            r_state     <= S_FAULT;
            r_busy      <= 1'b0;
            r_error     <= 1'b1;
            r_short     <= r_remaining;
            r_remaining <= '0;
          end else if (bus.coin_sensed) begin
            r_stock     <= w_stock_dec;
            r_remaining <= r_remaining - AMT_W'(1);
            r_pulse     <= '0;
            if (w_last_coin) begin
              r_state <= S_DONE;
              r_eject <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FIRE;
              r_eject <= (w_stock_dec != '0);
            end
          end else if (r_state == S_FIRE) begin
            if (r_pulse == c_PULSE_LAST) begin
              r_state <= S_WAIT_SENSE;
              r_eject <= 1'b0;
              r_wait  <= '0;
            end else begin
              r_pulse <= r_pulse + c_PW'(1);
            end
          end else if (r_wait == c_WAIT_LAST) begin
            r_state     <= S_FAULT;
            r_busy      <= 1'b0;
            r_error     <= 1'b1;
            r_short     <= r_remaining;
            r_remaining <= '0;
          end else begin
            r_wait <= r_wait + c_TW'(1);
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end

        S_FAULT: begin
          if (bus.clear_error) begin
            r_state <= S_IDLE;
            r_error <= 1'b0;
            r_ready <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_eject <= 1'b0;
          r_busy  <= 1'b0;
          r_error <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready    = r_ready;
  assign bus.eject_nickel = r_eject;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.error        = r_error;
  assign bus.short_amount = r_short;
  assign bus.stock_level  = r_stock;
  assign bus.empty        = (r_stock == '0);

endmodule

`default_nettype wire

// File: tb/tb_change_dispenser.sv
// ============================================================================
// Module   : tb_change_dispenser
// Brief    : Timeline model of each payout, replayed cycle by cycle against the DUT
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_change_dispenser;

  localparam int P = 4;
  localparam int T = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  change_dispenser_if #(.AMT_W(4), .STOCK_W(6)) bus ();

  change_dispenser #(
    .AMT_W(4), .STOCK_W(6), .STOCK_INIT(20), .PULSE_CYCLES(P), .TIMEOUT_CYCLES(T)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic       v;
    logic [3:0] amt;
    logic       coin;
    logic       rs;
    logic [5:0] rc;
    logic       clr;
  } stim_t;

  typedef struct packed {
    logic       ready;
    logic       eject;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] short_a;
    logic [5:0] stock;
    logic       empty;
  } exp_t;

  stim_t sq[$];
  exp_t  eq[$];
  int    m_stock;
  int    m_short;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_ej  = 0;
  int    cyc   = 0;

  function automatic int sat(int s, int r);
    return (s + r > 63) ? 63 : s + r;
  endfunction

  function automatic stim_t st(bit v, int amt, bit coin, bit rs, int rc, bit clr);
    stim_t s;
    s.v = v; s.amt = 4'(amt); s.coin = coin; s.rs = rs; s.rc = 6'(rc); s.clr = clr;
    return s;
  endfunction

  // Outputs expected in a cycle, given the model's stock and short at that cycle
  function automatic exp_t mk(bit ready, bit eject, bit busy, bit done, bit error);
    exp_t e;
    e.ready = ready; e.eject = eject; e.busy = busy; e.done = done; e.error = error;
    e.short_a = 4'(m_short); e.stock = 6'(m_stock); e.empty = (m_stock == 0);
    return e;
  endfunction

  // Inputs that must have no effect outside IDLE/FAULT, apart from the planned sense
  function automatic stim_t noise(bit coin);
    return st(1'($urandom), int'($urandom % 16), coin, 1'($urandom), int'($urandom % 64), 1'($urandom));
  endfunction

  function automatic void push(stim_t s, exp_t e);
    sq.push_back(s);
    eq.push_back(e);
  endfunction

  function automatic void idle(int n, bit rnd);
    for (int i = 0; i < n; i++) begin
      bit rs = rnd && ($urandom % 4 == 0);
      int rc = int'($urandom % 16);
      push(st(1'b0, int'($urandom % 16), rnd && 1'($urandom), rs, rc, rnd && 1'($urandom)),
           mk(1, 0, 0, 0, 0));
      if (rs) m_stock = sat(m_stock, rc);
    end
  endfunction

  function automatic void restock_cycle(int rc);
    push(st(0, 0, 0, 1, rc, 0), mk(1, 0, 0, 0, 0));
    m_stock = sat(m_stock, rc);
  endfunction

  function automatic void fault(int rem);
    int n = 1 + int'($urandom % 4);
    m_short = rem;
    for (int k = 0; k < n; k++) begin
      stim_t s = noise(1'($urandom));
      s.clr = (k == n - 1);
      push(s, mk(0, 0, 0, 0, 1));
    end
  endfunction

  // mode 0 random plan, 1 sense 3 cycles into WAIT, 2 never sense, 3 sense in 2nd pulse cycle
  function automatic void payout(int a, bit rs, int rc, int mode);
    int rem = a;
    push(st(1, a, 1'($urandom), rs, rc, 0), mk(1, 0, 0, 0, 0));
    if (rs) m_stock = sat(m_stock, rc);
    if (a == 0) begin
      push(noise(1'($urandom)), mk(0, 0, 0, 1, 0));
      return;
    end
    forever begin
      int  kind, p, w;
      bit  sensed = 0;
      if (m_stock == 0) begin
        push(noise(0), mk(0, 0, 1, 0, 0));
        fault(rem);
        return;
      end
      p = -1; w = -1;
      case (mode)
        1: w = 2;
        2: ;
        3: p = 1;
        default: begin
          kind = int'($urandom % 8);
          if (kind < 2)       p = int'($urandom % P);
          else if (kind == 7) w = T - 1;
          else if (kind != 2) w = int'($urandom % 6);
        end
      endcase
      for (int i = 0; i < P && !sensed; i++) begin
        push(noise(i == p), mk(0, 1, 1, 0, 0));
        if (i == p) sensed = 1;
      end
      for (int j = 0; j < T && !sensed; j++) begin
        push(noise(j == w), mk(0, 0, 1, 0, 0));
        if (j == w) sensed = 1;
      end
      if (!sensed) begin
        fault(rem);
        return;
      end
      m_stock--;
      rem--;
      if (rem == 0) begin
        push(noise(1'($urandom)), mk(0, 0, 0, 1, 0));
        return;
      end
    end
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Entered and left just after a rising edge; outputs compared mid-cycle
  task automatic run_queue();
    stim_t s;
    exp_t  e, g;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      e = eq.pop_front();
      bus.req_valid     = s.v;
      bus.req_amount    = s.amt;
      bus.coin_sensed   = s.coin;
      bus.restock       = s.rs;
      bus.restock_count = s.rc;
      bus.clear_error   = s.clr;
      @(negedge clock);
      g.ready = bus.req_ready;   g.eject = bus.eject_nickel; g.busy  = bus.busy;
      g.done  = bus.done;        g.error = bus.error;        g.short_a = bus.short_amount;
      g.stock = bus.stock_level; g.empty = bus.empty;
      if (g.eject === 1'b1) n_ej++;
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL cycle %0d: got rdy=%b ej=%b busy=%b done=%b err=%b short=%0d stock=%0d empty=%b, expected rdy=%b ej=%b busy=%b done=%b err=%b short=%0d stock=%0d empty=%b",
                 cyc, g.ready, g.eject, g.busy, g.done, g.error, g.short_a, g.stock, g.empty,
                 e.ready, e.eject, e.busy, e.done, e.error, e.short_a, e.stock, e.empty);
      end
      cyc++;
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 0; bus.req_amount = 0; bus.coin_sensed = 0;
    bus.restock = 0; bus.restock_count = 0; bus.clear_error = 0;
    m_stock = 20;
    m_short = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset req_ready", int'(bus.req_ready), 1);
    check("reset eject", int'(bus.eject_nickel), 0);
    check("reset stock", int'(bus.stock_level), 20);
    check("reset error", int'(bus.error), 0);
    check("reset short", int'(bus.short_amount), 0);
    @(posedge clock);
    #1;

    idle(2, 0);
    run_queue();

    n_ej = 0;
    payout(2, 0, 0, 1);
    idle(2, 0);
    run_queue();
    check("normal stock", int'(bus.stock_level), 18);
    check("normal eject cycles", n_ej, 8);
    check("normal busy", int'(bus.busy), 0);

    n_ej = 0;
    payout(0, 0, 0, 1);
    idle(1, 0);
    run_queue();
    check("zero stock", int'(bus.stock_level), 18);
    check("zero eject cycles", n_ej, 0);

    payout(15, 0, 0, 1);
    payout(3, 0, 0, 1);
    idle(1, 0);
    restock_cycle(1);
    payout(3, 0, 0, 1);
    idle(1, 0);
    run_queue();
    check("short amount", int'(bus.short_amount), 2);
    check("short stock", int'(bus.stock_level), 0);
    check("short empty", int'(bus.empty), 1);
    check("short ready", int'(bus.req_ready), 1);

    restock_cycle(5);
    payout(1, 0, 0, 2);
    idle(1, 0);
    run_queue();
    check("timeout short", int'(bus.short_amount), 1);
    check("timeout stock", int'(bus.stock_level), 5);

    restock_cycle(55);
    restock_cycle(10);
    idle(1, 0);
    run_queue();
    check("restock saturate", int'(bus.stock_level), 63);

    n_ej = 0;
    payout(1, 0, 0, 3);
    idle(1, 0);
    run_queue();
    check("early sense stock", int'(bus.stock_level), 62);
    check("early sense eject cycles", n_ej, 2);

    push(st(1, 3, 0, 0, 0, 0), mk(1, 0, 0, 0, 0));
    push(st(0, 0, 0, 0, 0, 0), mk(0, 1, 1, 0, 0));
    run_queue();
    check("mid pulse eject", int'(bus.eject_nickel), 1);
    reset = 1'b1;
    #1;
    check("async reset eject", int'(bus.eject_nickel), 0);
    check("async reset stock", int'(bus.stock_level), 20);
    check("async reset short", int'(bus.short_amount), 0);
    check("async reset ready", int'(bus.req_ready), 1);
    @(negedge clock);
    reset = 1'b0;
    m_stock = 20;
    m_short = 0;
    @(posedge clock);
    #1;

    for (int t = 0; t < 60; t++) begin
      idle(int'($urandom % 3), 1);
      payout(int'($urandom % 16), ($urandom % 4 == 0), int'($urandom % 16), 0);
      run_queue();
    end
    idle(2, 1);
    run_queue();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/change_dispenser.md
# change_dispenser

Pays out change in nickels for the vending machine. An item FSM hands it a change amount over a valid/ready handshake. The block drives the nickel-ejector solenoid one coin at a time and confirms each coin with the coin-path sensor. It also tracks the coin-tube inventory and reports completion, or a fault with the unpaid remainder.

## Interface
- AMT_W, 4, width of the requested change amount, in nickels
- STOCK_W, 6, width of the coin-tube inventory counter
- STOCK_INIT, 20, inventory value loaded at reset
- PULSE_CYCLES, 4, solenoid pulse length in clock cycles (must be ≥1)
- TIMEOUT_CYCLES, 64, cycles to wait for the sensor after a pulse (must be ≥1)

- clock  input  1  single clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  change request present
- req_amount  input  AMT_W  nickels to pay out
- req_ready  output  1  block can accept a request
- coin_sensed  input  1  single-cycle pulse when a nickel passes the exit sensor
- restock  input  1  add restock_count to inventory
- restock_count  input  STOCK_W  nickels being added
- clear_error  input  1  leave FAULT
- eject_nickel  output  1  solenoid drive, registered
- busy  output  1  payout in progress (FIRE or WAIT_SENSE)
- done  output  1  one-cycle pulse: payout complete
- error  output  1  held high while in FAULT
- short_amount  output  AMT_W  nickels left unpaid at the last fault
- stock_level  output  STOCK_W  current inventory
- empty  output  1  stock_level == 0

## Operation
- States: IDLE, FIRE, WAIT_SENSE, DONE, FAULT.
- req_ready = (state == IDLE). A request is accepted on an edge where req_valid && req_ready.
- **IDLE:**
  - On accept with req_amount == 0: go to DONE.
  - On any other accept: latch remaining = req_amount and go to FIRE.
- **FIRE:**
  - On entry with stock_level == 0: go to FAULT and set short_amount = remaining.
  - Otherwise assert eject_nickel for exactly PULSE_CYCLES cycles, then go to WAIT_SENSE with the timeout counter cleared.
- **WAIT_SENSE:**
  - On coin_sensed: decrement remaining and stock_level by 1.
  - If the new remaining is 0, go to DONE; otherwise go to FIRE.
  - If TIMEOUT_CYCLES consecutive cycles pass without coin_sensed: go to FAULT and set short_amount = remaining.
- **coin_sensed during a FIRE pulse:**
  - Counts as that coin's sense.
  - eject_nickel drops on the next edge.
  - The same decrement and transition as in WAIT_SENSE apply.
- coin_sensed in IDLE, DONE or FAULT is ignored: no count and no stock change.
- **DONE:** done = 1 for one cycle, then go to IDLE.
- **FAULT:**
  - eject_nickel = 0 and error = 1.
  - remaining is discarded.
  - clear_error goes to IDLE; short_amount keeps its value until the next fault.
- **Restock:**
  - Applies only in IDLE: stock_level ← min(stock_level + restock_count, 2^STOCK_W−1), computed at STOCK_W+1 bits and saturated.
  - Ignored in every other state.
  - Restock and an accept in the same IDLE cycle both take effect.
- Inventory never underflows; it is decremented only on a counted sense.

## Timing
- **Reset values:**
  - state IDLE, req_ready 1
  - eject_nickel 0, busy 0, done 0, error 0
  - short_amount 0, stock_level STOCK_INIT, empty (STOCK_INIT == 0)
- **Payout timing** (accept at edge N, stock > 0):
  - eject_nickel is high for cycles N+1 … N+PULSE_CYCLES.
  - WAIT_SENSE starts at cycle N+PULSE_CYCLES+1.
- **After a counted sense at edge M:**
  - Next pulse starts at M+1.
  - For the final coin, done is high during cycle M+1 and req_ready returns at M+2.
- A zero-amount accept at edge N gives done during cycle N+1.
- Timeout: the FAULT transition happens at the edge that ends the TIMEOUT_CYCLES-th waiting cycle. error is high from the following cycle.
- Reset mid-payout: eject_nickel drops asynchronously, and the remaining amount is lost.
- eject_nickel, done and error are glitch-free registered outputs.

## Test plan
- **Reset:** assert reset, release → req_ready=1, eject_nickel=0, stock_level=20, error=0, short_amount=0.
- **Normal payout:** req_amount=2 with stock 20, and coin_sensed 3 cycles into each WAIT_SENSE → two 4-cycle eject pulses, one done pulse, stock_level=18, busy low afterwards.
- **Zero request:** req_amount=0 → done the next cycle, no eject pulse, stock unchanged.
- **Inventory short:** restock from 0 to 1, then req_amount=3 → one coin paid, then FAULT with short_amount=2, stock_level=0, empty=1. error stays high until clear_error, then req_ready=1.
- **Timeout:** req_amount=1 with coin_sensed never asserted → FAULT exactly 64 cycles after the pulse ends, short_amount=1, stock unchanged. A stray coin_sensed in FAULT is ignored.
- **Restock and reset corners:**
  - stock 60 + restock_count 10 → 63.
  - Restock during FIRE is ignored.
  - coin_sensed during a FIRE pulse ends the pulse early and counts the coin.
  - reset asserted mid-pulse → eject_nickel=0 immediately and stock_level=20.
